// File: rtl/odometer_meas_ctrl.sv
// Measurement sequencer for the odometer/VCO macro: reset, configure, trigger, stress, measure, capture.
// Optional ODO_DELTA_EN adds RES_DELTA, the signed change versus the previous capture for the same select.
module odometer_meas_ctrl #(
  parameter int unsigned COUNT_W    = 12,
  parameter int unsigned STRESS_W   = 16,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned LOAD_CYC   = 2,
  parameter int unsigned TRIG_CYC   = 5,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_AC_DC,
  input  logic [2:0]          REQ_SEL,
  input  logic [STRESS_W-1:0] REQ_STRESS,
  input  logic [COUNT_W-1:0]  BF_COUNT,
  output logic                RESETB,
  output logic                LOAD,
  output logic                MEAS_TRIG,
  output logic                START,
  output logic                AC_DC,
  output logic                SEL_INV,
  output logic                SEL_NAND,
  output logic                SEL_NOR,
  output logic                EN_VCO,
  output logic                CLK_KILL,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic [COUNT_W-1:0]  RES_COUNT,
  output logic [2:0]          RES_SEL,
  output logic                RES_ERR,
  output logic                BUSY
`ifdef ODO_DELTA_EN
  ,
  output logic signed [COUNT_W:0] RES_DELTA
`endif
);

  localparam int unsigned CNT_W = (STRESS_W > 8) ? STRESS_W : 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST     = 3'd1;
  localparam logic [2:0] S_CFG     = 3'd2;
  localparam logic [2:0] S_TRIG    = 3'd3;
  localparam logic [2:0] S_STRESS  = 3'd4;
  localparam logic [2:0] S_MEAS    = 3'd5;
  localparam logic [2:0] S_CAPTURE = 3'd6;
  localparam logic [2:0] S_RESULT  = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ac_dc_lat_q, ac_dc_lat_d;
  logic [2:0]          sel_lat_q, sel_lat_d;
  logic [STRESS_W-1:0] stress_q, stress_d;
  logic                resetb_q, resetb_d;
  logic                load_q, load_d;
  logic                meas_trig_q, meas_trig_d;
  logic                start_q, start_d;
  logic                ac_dc_q, ac_dc_d;
  logic [2:0]          sel_out_q, sel_out_d;
  logic                en_vco_q, en_vco_d;
  logic                clk_kill_q, clk_kill_d;
  logic                res_valid_q, res_valid_d;
  logic [COUNT_W-1:0]  res_count_q, res_count_d;
  logic [2:0]          res_sel_q, res_sel_d;
  logic                res_err_q, res_err_d;
  logic                busy_q, busy_d;
  logic                req_ready_q, req_ready_d;
`ifdef ODO_DELTA_EN
  logic [2:0][COUNT_W-1:0] prev_q, prev_d;
  logic [2:0]              seen_q, seen_d;
  logic signed [COUNT_W:0] delta_q, delta_d;
`endif

  // Next state and pin decode; pins are registered from the current state, so they trail it by one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    ac_dc_lat_d = ac_dc_lat_q;
    sel_lat_d   = sel_lat_q;
    stress_d    = stress_q;
    resetb_d    = resetb_q;
    load_d      = load_q;
    meas_trig_d = meas_trig_q;
    start_d     = start_q;
    ac_dc_d     = ac_dc_q;
    sel_out_d   = sel_out_q;
    en_vco_d    = en_vco_q;
    clk_kill_d  = clk_kill_q;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_sel_d   = res_sel_q;
    res_err_d   = res_err_q;
`ifdef ODO_DELTA_EN
    prev_d  = prev_q;
    seen_d  = seen_q;
    delta_d = delta_q;
`endif

    case (state_q)
      S_IDLE: begin
        resetb_d    = 1'b1;
        meas_trig_d = 1'b1;
        start_d     = 1'b0;
        en_vco_d    = 1'b0;
        clk_kill_d  = 1'b0;
        if (REQ_VALID && req_ready_q) begin
          ac_dc_lat_d = REQ_AC_DC;
          sel_lat_d   = REQ_SEL;
          stress_d    = REQ_STRESS;
          if ($onehot(REQ_SEL)) begin
            state_d = S_RST;
          end else begin
            state_d     = S_RESULT;
            res_err_d   = 1'b1;
            res_count_d = '0;
            res_sel_d   = REQ_SEL;
`ifdef ODO_DELTA_EN
            delta_d = '0;
`endif
          end
        end
      end
      S_RST: begin
        resetb_d = 1'b0;
        if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = S_CFG;
      end
      S_CFG: begin
        resetb_d  = 1'b1;
        en_vco_d  = 1'b1;
        ac_dc_d   = ac_dc_lat_q;
        sel_out_d = sel_lat_q;
        start_d   = 1'b0;
        load_d    = (cnt_q == CNT_W'(LOAD_CYC));
        if (cnt_q == CNT_W'(LOAD_CYC)) state_d = S_TRIG;
      end
      S_TRIG: begin
        meas_trig_d = 1'b0;
        if (cnt_q == CNT_W'(TRIG_CYC - 1)) state_d = S_MEAS - 3'd1;
      end
      S_STRESS: begin
        meas_trig_d = 1'b1;
        start_d     = 1'b1;
        clk_kill_d  = 1'b0;
        // Zero requested stress still spends one cycle here.
        if ((stress_q == '0) || (cnt_q == CNT_W'(stress_q) - CNT_W'(1))) state_d = S_MEAS;
      end
      S_MEAS: begin
        clk_kill_d  = 1'b1;
        start_d     = 1'b0;
        meas_trig_d = 1'b0;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_count_d = BF_COUNT;
        res_sel_d   = sel_lat_q;
        res_err_d   = 1'b0;
        meas_trig_d = 1'b1;
        state_d     = S_RESULT;
`ifdef ODO_DELTA_EN
        delta_d = '0;
        for (int i = 0; i < 3; i++) begin
          if (sel_lat_q[i]) begin
            if (seen_q[i]) delta_d = $signed({1'b0, BF_COUNT}) - $signed({1'b0, prev_q[i]});
            prev_d[i] = BF_COUNT;
            seen_d[i] = 1'b1;
          end
        end
`endif
      end
      S_RESULT: begin
        res_valid_d = 1'b1;
        if (res_valid_q && RES_READY) begin
          res_valid_d = 1'b0;
          en_vco_d    = 1'b0;
          clk_kill_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ac_dc_lat_q <= 1'b0;
      sel_lat_q   <= '0;
      stress_q    <= '0;
      resetb_q    <= 1'b1;
      load_q      <= 1'b0;
      meas_trig_q <= 1'b1;
      start_q     <= 1'b0;
      ac_dc_q     <= 1'b0;
      sel_out_q   <= '0;
      en_vco_q    <= 1'b0;
      clk_kill_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_sel_q   <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
`ifdef ODO_DELTA_EN
      prev_q  <= '0;
      seen_q  <= '0;
      delta_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ac_dc_lat_q <= ac_dc_lat_d;
      sel_lat_q   <= sel_lat_d;
      stress_q    <= stress_d;
      resetb_q    <= resetb_d;
      load_q      <= load_d;
      meas_trig_q <= meas_trig_d;
      start_q     <= start_d;
      ac_dc_q     <= ac_dc_d;
      sel_out_q   <= sel_out_d;
      en_vco_q    <= en_vco_d;
      clk_kill_q  <= clk_kill_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_sel_q   <= res_sel_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
`ifdef ODO_DELTA_EN
      prev_q  <= prev_d;
      seen_q  <= seen_d;
      delta_q <= delta_d;
`endif
    end
  end

  assign REQ_READY = req_ready_q;
  assign RESETB    = resetb_q;
  assign LOAD      = load_q;
  assign MEAS_TRIG = meas_trig_q;
  assign START     = start_q;
  assign AC_DC     = ac_dc_q;
  assign SEL_INV   = sel_out_q[0];
  assign SEL_NAND  = sel_out_q[1];
  assign SEL_NOR   = sel_out_q[2];
  assign EN_VCO    = en_vco_q;
  assign CLK_KILL  = clk_kill_q;
  assign RES_VALID = res_valid_q;
  assign RES_COUNT = res_count_q;
  assign RES_SEL   = res_sel_q;
  assign RES_ERR   = res_err_q;
  assign BUSY      = busy_q;
`ifdef ODO_DELTA_EN
  assign RES_DELTA = delta_q;
`endif

endmodule

// File: tb/tb_odometer_meas_ctrl.sv
// Directed bench for odometer_meas_ctrl; define ODO_DELTA_EN to also exercise RES_DELTA.
module tb_odometer_meas_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_AC_DC;
  logic [2:0]  REQ_SEL;
  logic [15:0] REQ_STRESS;
  logic [11:0] BF_COUNT;
  logic        RESETB, LOAD, MEAS_TRIG, START, AC_DC;
  logic        SEL_INV, SEL_NAND, SEL_NOR, EN_VCO, CLK_KILL;
  logic        RES_VALID;
  logic        RES_READY;
  logic [11:0] RES_COUNT;
  logic [2:0]  RES_SEL;
  logic        RES_ERR;
  logic        BUSY;
`ifdef ODO_DELTA_EN
  logic signed [12:0] RES_DELTA;
`endif

  int tests = 0;
  int fails = 0;

  // Per-run observations, cycle k counted from the accepting edge (k=0).
  int lat, first_rb_low, first_en_vco, first_load_hi, first_trig_low, first_start, first_kill;
  int rb_low_cnt, trig_low_cnt, pin_toggles;

  odometer_meas_ctrl dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_AC_DC(REQ_AC_DC), .REQ_SEL(REQ_SEL), .REQ_STRESS(REQ_STRESS), .BF_COUNT(BF_COUNT),
    .RESETB(RESETB), .LOAD(LOAD), .MEAS_TRIG(MEAS_TRIG), .START(START), .AC_DC(AC_DC),
    .SEL_INV(SEL_INV), .SEL_NAND(SEL_NAND), .SEL_NOR(SEL_NOR), .EN_VCO(EN_VCO),
    .CLK_KILL(CLK_KILL), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_COUNT(RES_COUNT), .RES_SEL(RES_SEL), .RES_ERR(RES_ERR), .BUSY(BUSY)
`ifdef ODO_DELTA_EN
    , .RES_DELTA(RES_DELTA)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic ac, input logic [2:0] sel, input logic [15:0] stress,
                      input logic [11:0] bf);
    check("req_ready_before_send", REQ_READY, 1);
    REQ_AC_DC  = ac;
    REQ_SEL    = sel;
    REQ_STRESS = stress;
    BF_COUNT   = bf;
    REQ_VALID  = 1'b1;
    step();
    REQ_VALID  = 1'b0;
  endtask

  // Watch pins until RES_VALID rises or the budget runs out.
  task automatic wait_valid(input int limit);
    logic prev_rb, prev_ld, prev_mt;
    lat = -1; first_rb_low = -1; first_en_vco = -1; first_load_hi = -1;
    first_trig_low = -1; first_start = -1; first_kill = -1;
    rb_low_cnt = 0; trig_low_cnt = 0; pin_toggles = 0;
    prev_rb = RESETB; prev_ld = LOAD; prev_mt = MEAS_TRIG;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (!RESETB) rb_low_cnt++;
      if (!MEAS_TRIG) trig_low_cnt++;
      if (!RESETB && first_rb_low < 0) first_rb_low = k;
      if (EN_VCO && first_en_vco < 0) first_en_vco = k;
      if (LOAD && !prev_ld && first_load_hi < 0) first_load_hi = k;
      if (!MEAS_TRIG && first_trig_low < 0) first_trig_low = k;
      if (START && first_start < 0) first_start = k;
      if (CLK_KILL && first_kill < 0) first_kill = k;
      if (RESETB !== prev_rb || LOAD !== prev_ld || MEAS_TRIG !== prev_mt) pin_toggles++;
      prev_rb = RESETB; prev_ld = LOAD; prev_mt = MEAS_TRIG;
      if (RES_VALID) begin
        lat = k;
        break;
      end
    end
    check("res_valid_within_budget", 32'(lat > 0), 1);
  endtask

  task automatic accept_result();
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    check("res_valid_drops", RES_VALID, 0);
    check("req_ready_after_xfer", REQ_READY, 1);
    check("en_vco_off_after_xfer", EN_VCO, 0);
    check("clk_kill_off_after_xfer", CLK_KILL, 0);
  endtask

  initial begin
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_AC_DC = 1'b0; REQ_SEL = '0;
    REQ_STRESS = '0; BF_COUNT = '0; RES_READY = 1'b0;
    repeat (3) step();

    check("rst_resetb", RESETB, 1);
    check("rst_load", LOAD, 0);
    check("rst_meas_trig", MEAS_TRIG, 1);
    check("rst_start", START, 0);
    check("rst_ac_dc", AC_DC, 0);
    check("rst_sel", {SEL_NOR, SEL_NAND, SEL_INV}, 0);
    check("rst_en_vco", EN_VCO, 0);
    check("rst_clk_kill", CLK_KILL, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_count", RES_COUNT, 0);
    check("rst_res_sel", RES_SEL, 0);
    check("rst_res_err", RES_ERR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_req_ready", REQ_READY, 1);
    RESET = 1'b0;
    step();

    // INV, DC, 20 stress cycles
    send(1'b0, 3'b001, 16'd20, 12'h0A5);
    check("busy_after_accept", BUSY, 1);
    wait_valid(200);
    check("lat_s20", lat, 42);
    check("resetb_low_at", first_rb_low, 1);
    check("resetb_low_len", rb_low_cnt, 4);
    check("en_vco_at", first_en_vco, 5);
    check("load_rise_at", first_load_hi, 7);
    check("trig_low_at", first_trig_low, 8);
    check("trig_low_len", trig_low_cnt, 13);
    check("start_at", first_start, 13);
    check("clk_kill_at", first_kill, 33);
    check("res_count_s20", RES_COUNT, 12'h0A5);
    check("res_sel_s20", RES_SEL, 3'b001);
    check("res_err_s20", RES_ERR, 0);
    check("sel_pins_s20", {SEL_NOR, SEL_NAND, SEL_INV}, 3'b001);
    check("ac_dc_s20", AC_DC, 0);
    check("meas_trig_idle_high", MEAS_TRIG, 1);

    // Back-pressure with a competing request that must be ignored
    REQ_VALID = 1'b1; REQ_SEL = 3'b100; REQ_STRESS = 16'd3; BF_COUNT = 12'h777;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", RES_VALID, 1);
      check("hold_count", RES_COUNT, 12'h0A5);
      check("hold_req_ready", REQ_READY, 0);
    end
    REQ_VALID = 1'b0;
    accept_result();
    check("load_stays_high", LOAD, 1);
    check("sel_holds", {SEL_NOR, SEL_NAND, SEL_INV}, 3'b001);
    step();
    check("competing_req_not_taken", BUSY, 0);
    check("competing_resetb_idle", RESETB, 1);

    // Non-one-hot select is rejected without pin activity
    send(1'b1, 3'b011, 16'd5, 12'h123);
    wait_valid(20);
    check("lat_err", lat, 1);
    check("err_flag", RES_ERR, 1);
    check("err_count", RES_COUNT, 0);
    check("err_sel", RES_SEL, 3'b011);
    check("err_no_pin_toggle", pin_toggles, 0);
    check("err_load_still_high", LOAD, 1);
    accept_result();

    // NAND, AC, zero stress
    send(1'b1, 3'b010, 16'd0, 12'h03C);
    wait_valid(200);
    check("lat_s0", lat, 23);
    check("start_at_s0", first_start, 13);
    check("clk_kill_at_s0", first_kill, 14);
    check("res_count_s0", RES_COUNT, 12'h03C);
    check("res_sel_s0", RES_SEL, 3'b010);
    check("res_err_s0", RES_ERR, 0);
    check("ac_dc_s0", AC_DC, 1);
    check("sel_pins_s0", {SEL_NOR, SEL_NAND, SEL_INV}, 3'b010);
    accept_result();

    // Reset while stressing
    send(1'b0, 3'b100, 16'd20, 12'h555);
    begin
      int waited;
      waited = 0;
      while (!START && waited < 50) begin
        step();
        waited++;
      end
      check("reached_stress", START, 1);
    end
    RESET = 1'b1;
    step();
    check("midrst_clk_kill", CLK_KILL, 0);
    check("midrst_en_vco", EN_VCO, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_res_valid", RES_VALID, 0);
    check("midrst_start", START, 0);
    check("midrst_load", LOAD, 0);
    check("midrst_sel", {SEL_NOR, SEL_NAND, SEL_INV}, 0);
    check("midrst_req_ready", REQ_READY, 1);
    RESET = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (RES_VALID || BUSY) seen++;
      end
      check("no_partial_result", seen, 0);
    end

`ifdef ODO_DELTA_EN
    send(1'b0, 3'b001, 16'd2, 12'd100);
    wait_valid(200);
    check("delta_inv_first", 32'(int'(RES_DELTA)), 32'd0);
    accept_result();
    send(1'b0, 3'b001, 16'd2, 12'd90);
    wait_valid(200);
    check("delta_inv_second", 32'(int'(RES_DELTA)), 32'hFFFF_FFF6);
    accept_result();
    send(1'b0, 3'b011, 16'd2, 12'd50);
    wait_valid(20);
    check("delta_err", 32'(int'(RES_DELTA)), 32'd0);
    accept_result();
    send(1'b0, 3'b010, 16'd2, 12'd70);
    wait_valid(200);
    check("delta_nand_first", 32'(int'(RES_DELTA)), 32'd0);
    accept_result();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/odometer_meas_ctrl.md
Name: odometer_meas_ctrl

Overview:
On-chip measurement sequencer that drives the odometer_full_rvt / VCO_full control pins (RESETB, LOAD, MEAS_TRIG, START, AC_DC, SEL_*, EN_VCO, CLK_KILL). It plays the initiator role that the bench plays today: configure, stress, measure, then capture BF_COUNT. One request/result pair uses a valid/ready handshake on each side. It sits between the chip control/scan logic and the odometer macro.

Parameters:
COUNT_W, 12, BF_COUNT / result width
STRESS_W, 16, width of stress-duration field (CLK cycles)
RST_CYC, 4, cycles RESETB held low at sequence start
LOAD_CYC, 2, cycles LOAD held low before rising
TRIG_CYC, 5, cycles MEAS_TRIG held low for each trigger pulse
SETTLE_CYC, 8, cycles MEAS_TRIG held low in measure phase before capture

Ports:
CLK  in  1  controller clock (also source of AC_STRESS_CLK domain)
RESET  in  1  synchronous, active-high reset
REQ_VALID  in  1  measurement request valid
REQ_READY  out  1  high only in IDLE
REQ_AC_DC  in  1  stress mode: 0 = DC, 1 = AC
REQ_SEL  in  3  {NOR,NAND,INV} select; must be one-hot
REQ_STRESS  in  STRESS_W  stress duration in CLK cycles
BF_COUNT  in  COUNT_W  odometer beat-frequency count
RESETB  out  1  odometer/VCO reset, active-low
LOAD  out  1  odometer load
MEAS_TRIG  out  1  measurement trigger, active-low pulse
START  out  1  odometer start
AC_DC  out  1  registered stress mode
SEL_INV, SEL_NAND, SEL_NOR  out  1 each  registered select
EN_VCO  out  1  VCO enable
CLK_KILL  out  1  stress clock gate
RES_VALID  out  1  result valid
RES_READY  in  1  result accepted
RES_COUNT  out  COUNT_W  captured BF_COUNT
RES_SEL  out  3  select used for this result
RES_ERR  out  1  request rejected (select not one-hot)
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset values: RESETB=1, LOAD=0, MEAS_TRIG=1, START=0, AC_DC=0, SEL_*=0, EN_VCO=0, CLK_KILL=0, RES_VALID=0, RES_COUNT=0, RES_SEL=0, RES_ERR=0, BUSY=0, REQ_READY=1. State = IDLE.
- All outputs are registered; one state counter (width sufficient for max(STRESS, params)).
- IDLE: on REQ_VALID&&REQ_READY, latch REQ_AC_DC, REQ_SEL, REQ_STRESS. If REQ_SEL is not one-hot: go to RESULT with RES_ERR=1, RES_COUNT=0, no pin activity. Otherwise go to RST.
- RST: RESETB=0 for RST_CYC cycles -> CFG.
- CFG: RESETB=1, EN_VCO=1, AC_DC/SEL_* driven from latch, START=0, LOAD=0 for LOAD_CYC cycles, then LOAD=1 -> TRIG.
- TRIG: MEAS_TRIG=0 for TRIG_CYC cycles, then 1 -> STRESS.
- STRESS: START=1, CLK_KILL=0; count REQ_STRESS cycles. REQ_STRESS=0 means zero stress cycles (STRESS lasts exactly 1 cycle) -> MEAS.
- MEAS: CLK_KILL=1, START=0, MEAS_TRIG=0 for SETTLE_CYC cycles -> CAPTURE.
- CAPTURE: one cycle; RES_COUNT <= BF_COUNT, RES_SEL <= latched sel, RES_ERR <= 0, MEAS_TRIG=1 -> RESULT.
- RESULT: RES_VALID=1, held with stable data until RES_READY. Transfer -> IDLE, RES_VALID=0, EN_VCO=0, CLK_KILL=0, LOAD stays 1, SEL_* hold.
- Latency, valid request to RES_VALID: 1+RST_CYC+LOAD_CYC+1+TRIG_CYC+max(REQ_STRESS,1)+SETTLE_CYC+1 cycles.
- REQ_VALID while BUSY is ignored: REQ_READY=0, nothing is latched.
- RESET mid-sequence returns all outputs to reset values on the next edge. No partial result is emitted.

Optional Feature:
ODO_DELTA_EN: when defined, add output RES_DELTA [COUNT_W:0], signed. It holds RES_COUNT minus the previous captured count for the same select (three stored registers). The first capture per select after RESET gives RES_DELTA=0. Error results give RES_DELTA=0 and leave the stored registers unchanged. When not defined, the port and registers do not exist.

Test Plan:
- RESET=1 for 3 cycles -> all outputs at reset values, REQ_READY=1. RESET is then released.
- REQ_SEL=3'b001, AC_DC=0, REQ_STRESS=20, BF_COUNT=12'h0A5 -> pin sequence in order RST/CFG/TRIG/STRESS/MEAS. RES_VALID rises at cycle 1+4+2+1+5+20+8+1 = 42 with RES_COUNT=0x0A5 and RES_SEL=001.
- REQ_SEL=3'b011 -> RES_VALID after 1 cycle, RES_ERR=1, RESETB/LOAD/MEAS_TRIG never toggle.
- Hold RES_READY=0 for 10 cycles -> RES_VALID and RES_COUNT stay stable. A second REQ_VALID in that window is not accepted.
- Assert RESET during STRESS -> the next cycle has CLK_KILL=0, EN_VCO=0, BUSY=0, and no RES_VALID.
- With ODO_DELTA_EN: two INV runs with BF_COUNT=100 then 90 -> RES_DELTA=0, then -10. A NAND run after these -> RES_DELTA=0.
